// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory stage (mem_lsu) and its alignment helper.
//  - MEM_* memory operation codes carried on mem_op_i
//  - EXC_* bit positions in the exception vector
//  - FSM state type for the bus transaction controller
//  - small decode helpers for load/store/misalignment classification
package mem_lsu_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam int unsigned EXC_LD_MISALIGN = 4;
  localparam int unsigned EXC_LD_FAULT    = 5;
  localparam int unsigned EXC_ST_MISALIGN = 6;
  localparam int unsigned EXC_ST_FAULT    = 7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDone  = 2'd2,
    StDrain = 2'd3
  } lsu_state_e;

  function automatic logic is_load(logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword ops need a[0]==0, word ops need a[1:0]==0.
  function automatic logic is_misaligned(logic [3:0] op, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = off[0];
      MEM_LW, MEM_SW:          mis = |off;
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Purely combinational lane logic for the memory stage.
//  Store side: byte enables and lane-replicated write data from op/address offset.
//  Load side : picks the byte/half selected by the offset and sign/zero-extends it.
// Ports:
//  st_op_i/st_off_i/st_data_i  store op, address[1:0], LSB-aligned store data
//  be_o/wdata_o                byte enables (0 for loads) and replicated write data
//  ld_op_i/ld_off_i/rdata_i    load op, address[1:0] and raw bus read data
//  ld_data_o                   formatted load result
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  st_op_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [3:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    case (st_op_i)
      MEM_SB: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      MEM_SH: begin
        be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
      end
      MEM_SW: begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ld_data_o = 32'h0;
    case (ld_op_i)
      MEM_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_data_o = {24'h0, ld_byte};
      MEM_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: ld_data_o = {16'h0, ld_half};
      MEM_LW:  ld_data_o = rdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage of the 5-stage RISC-V core (between exe_mem and mem_wb).
// Runs the data-bus req/ack transaction for loads/stores, formats load data, stalls the
// pipeline until the access completes and passes writeback/csr/exception fields through.
// Optional feature macro: MEM_MISALIGN_EXC_EN -- when defined, misaligned halfword/word
// accesses raise a misalignment exception instead of wrapping inside the word.
// Ports:
//  clk_i, rst_i (async, active-low)
//  reg_*_i / csr_*_i / inst_addr_i / exception_i : fields from exe_mem
//  mem_we_i, mem_addr_i, mem_data_i, mem_op_i     : memory access request
//  flush_int_i                                    : interrupt/exception flush
//  dbus_*                                         : data bus (registered request side)
//  stall_req_o                                    : hold IF..EXE and exe_mem
//  reg_*_o / csr_*_o / inst_addr_o / exception_o  : to mem_wb
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  mem_op_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] exception_i,
  input  logic        flush_int_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stall_req_o,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] exception_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  lsu_state_e    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic          fault_q, fault_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld_data;
  logic        misalign;
  logic        start;
  logic [31:0] local_exc;

  // Store lanes come from the live request (registered at issue); load formatting uses the
  // op/offset captured at issue so it is independent of what exe_mem presents later.
  mem_lsu_align u_align (
    .st_op_i  (mem_op_i),
    .st_off_i (mem_addr_i[1:0]),
    .st_data_i(mem_data_i),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .ld_op_i  (op_q),
    .ld_off_i (off_q),
    .rdata_i  (dbus_rdata_i),
    .ld_data_o(al_ld_data)
  );

`ifdef MEM_MISALIGN_EXC_EN
  assign misalign = is_misaligned(mem_op_i, mem_addr_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign start = (mem_op_i != MEM_NOP) && !flush_int_i && !misalign;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    ld_data_d   = ld_data_q;
    op_d        = op_q;
    off_d       = off_q;
    fault_d     = fault_q;
    tmo_cnt_d   = tmo_cnt_q;
    stall_req_o = 1'b0;
    local_exc   = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          req_d       = 1'b1;
          we_d        = mem_we_i & is_store(mem_op_i);
          addr_d      = {mem_addr_i[31:2], 2'b00};
          be_d        = al_be;
          wdata_d     = al_wdata;
          op_d        = mem_op_i;
          off_d       = mem_addr_i[1:0];
          fault_d     = 1'b0;
          tmo_cnt_d   = '0;
          stall_req_o = 1'b1;
          state_d     = StBusy;
        end else if (misalign && !flush_int_i) begin
          if (is_load(mem_op_i)) local_exc[EXC_LD_MISALIGN] = 1'b1;
          else                   local_exc[EXC_ST_MISALIGN] = 1'b1;
        end
      end
      StBusy: begin
        stall_req_o = 1'b1;
        tmo_cnt_d   = tmo_cnt_q + 1'b1;
        if (dbus_ack_i) begin
          req_d     = 1'b0;
          ld_data_d = al_ld_data;
          fault_d   = dbus_err_i;
          // A flush arriving with the ack has nothing left to drain.
          state_d   = flush_int_i ? StIdle : StDone;
        end else if (flush_int_i) begin
          state_d = StDrain;
        end else if (tmo_cnt_q == TmoLast) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (fault_q && !flush_int_i) begin
          if (is_load(op_q)) local_exc[EXC_LD_FAULT] = 1'b1;
          else               local_exc[EXC_ST_FAULT] = 1'b1;
        end
      end
      StDrain: begin
        // Keep the bus transaction alive; only hold the pipe if a new access is waiting.
        stall_req_o = (mem_op_i != MEM_NOP);
        if (dbus_ack_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'b0000;
      ld_data_q <= 32'h0;
      op_q      <= MEM_NOP;
      off_q     <= 2'b00;
      fault_q   <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      ld_data_q <= ld_data_d;
      op_q      <= op_d;
      off_q     <= off_d;
      fault_q   <= fault_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = wdata_q;
  assign dbus_be_o    = be_q;

  assign reg_waddr_o = reg_waddr_i;
  assign reg_we_o    = reg_we_i && !stall_req_o && (state_q != StDrain) &&
                       !(|local_exc) && !flush_int_i;
  assign reg_wdata_o = ((state_q == StDone) && is_load(op_q) && !flush_int_i) ?
                       ld_data_q : reg_wdata_i;

  assign csr_we_o    = csr_we_i;
  assign csr_waddr_o = csr_waddr_i;
  assign csr_wdata_o = csr_wdata_i;
  assign inst_addr_o = inst_addr_i;
  assign exception_o = exception_i | local_exc;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_op_i;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] inst_addr_i;
  logic [31:0] exception_i;
  logic        flush_int_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_ack_i;
  logic        dbus_err_i;
  logic [31:0] dbus_rdata_i;
  logic        stall_req_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] inst_addr_o;
  logic [31:0] exception_o;

  int tests_run = 0;
  int tests_failed = 0;

  mem_lsu dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reg_waddr_i (reg_waddr_i),
    .reg_we_i    (reg_we_i),
    .reg_wdata_i (reg_wdata_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_op_i    (mem_op_i),
    .csr_we_i    (csr_we_i),
    .csr_waddr_i (csr_waddr_i),
    .csr_wdata_i (csr_wdata_i),
    .inst_addr_i (inst_addr_i),
    .exception_i (exception_i),
    .flush_int_i (flush_int_i),
    .dbus_req_o  (dbus_req_o),
    .dbus_we_o   (dbus_we_o),
    .dbus_addr_o (dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o),
    .dbus_be_o   (dbus_be_o),
    .dbus_ack_i  (dbus_ack_i),
    .dbus_err_i  (dbus_err_i),
    .dbus_rdata_i(dbus_rdata_i),
    .stall_req_o (stall_req_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_we_o    (reg_we_o),
    .reg_wdata_o (reg_wdata_o),
    .csr_we_o    (csr_we_o),
    .csr_waddr_o (csr_waddr_o),
    .csr_wdata_o (csr_wdata_o),
    .inst_addr_o (inst_addr_o),
    .exception_o (exception_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_nop();
    mem_op_i    = OP_NOP;
    mem_we_i    = 1'b0;
    mem_addr_i  = 32'h0;
    mem_data_i  = 32'h0;
    reg_we_i    = 1'b0;
    reg_waddr_i = 5'd0;
    reg_wdata_i = 32'h0;
    csr_we_i    = 1'b0;
    csr_waddr_i = 12'h0;
    csr_wdata_i = 32'h0;
    inst_addr_i = 32'h0;
    exception_i = 32'h0;
    flush_int_i = 1'b0;
    dbus_ack_i  = 1'b0;
    dbus_err_i  = 1'b0;
    dbus_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    drive_nop();
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #20;
    tests_run++;
    if (dbus_req_o !== 1'b0) begin
      $display("FAIL reset_req: got %b want 0", dbus_req_o); tests_failed++;
    end
    tests_run++;
    if ({dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o} !== 69'h0) begin
      $display("FAIL reset_bus: we=%b be=%b addr=%h wdata=%h want all 0",
               dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o); tests_failed++;
    end
    tests_run++;
    if (stall_req_o !== 1'b0) begin
      $display("FAIL reset_stall: got %b want 0", stall_req_o); tests_failed++;
    end
    @(negedge clk_i) rst_i = 1'b1;
    tick();
  endtask

  task automatic test_lb();
    int stalls;
    stalls = 0;
    mem_op_i = OP_LB; mem_addr_i = 32'h0000_1003; reg_we_i = 1'b1; reg_waddr_i = 5'd9;
    reg_wdata_i = 32'h1111; csr_we_i = 1'b1; csr_waddr_i = 12'h305; csr_wdata_i = 32'h8000_0100;
    inst_addr_i = 32'h0000_0040;
    #1;
    if (stall_req_o) stalls++;
    tests_run++;
    if ({csr_we_o, csr_waddr_o, csr_wdata_o, inst_addr_o} !==
        {1'b1, 12'h305, 32'h8000_0100, 32'h0000_0040}) begin
      $display("FAIL lb_passthru: csr_we=%b csr_waddr=%h csr_wdata=%h pc=%h", csr_we_o,
               csr_waddr_o, csr_wdata_o, inst_addr_o); tests_failed++;
    end
    tick();
    if (stall_req_o) stalls++;
    tests_run++;
    if ({dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o} !== {1'b1, 1'b0, 4'b0000, 32'h1000}) begin
      $display("FAIL lb_issue: req=%b we=%b be=%b addr=%h want 1 0 0000 00001000",
               dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o); tests_failed++;
    end
    tests_run++;
    if (reg_we_o !== 1'b0) begin
      $display("FAIL lb_we_during_stall: got %b want 0", reg_we_o); tests_failed++;
    end
    tick();
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h8012_3456;
    #1;
    if (stall_req_o) stalls++;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    tests_run++;
    if ({stall_req_o, dbus_req_o} !== 2'b00) begin
      $display("FAIL lb_done_ctrl: stall=%b req=%b want 0 0", stall_req_o, dbus_req_o);
      tests_failed++;
    end
    tests_run++;
    if ({reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd9, 32'hFFFF_FF80}) begin
      $display("FAIL lb_result: we=%b rd=%0d data=%h want 1 9 ffffff80", reg_we_o,
               reg_waddr_o, reg_wdata_o); tests_failed++;
    end
    tests_run++;
    if (stalls != 3) begin
      $display("FAIL lb_stall_cycles: got %0d want 3", stalls); tests_failed++;
    end
    tick();
    drive_nop();
  endtask

  task automatic test_sh();
    mem_op_i = OP_SH; mem_we_i = 1'b1; mem_addr_i = 32'h0000_2002; mem_data_i = 32'h1234_ABCD;
    tick();
    tests_run++;
    if ({dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o} !==
        {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCD_ABCD}) begin
      $display("FAIL sh_bus: req=%b we=%b be=%b addr=%h wdata=%h want 1 1 1100 2000 abcdabcd",
               dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o); tests_failed++;
    end
    dbus_ack_i = 1'b1;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    tests_run++;
    if ({stall_req_o, dbus_req_o, exception_o} !== {2'b00, 32'h0}) begin
      $display("FAIL sh_done: stall=%b req=%b exc=%h want 0 0 0", stall_req_o, dbus_req_o,
               exception_o); tests_failed++;
    end
    tick();
    drive_nop();
  endtask

  task automatic test_load_formats();
    logic [3:0]  ops[5]   = '{OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LW};
    logic [31:0] addrs[5] = '{32'h1001, 32'h1002, 32'h1002, 32'h1000, 32'h1004};
    logic [31:0] rds[5]   = '{32'h0000_F500, 32'h8001_0000, 32'h8001_0000, 32'h0000_007F,
                              32'h1234_5678};
    logic [31:0] exps[5]  = '{32'h0000_00F5, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F,
                              32'h1234_5678};
    for (int i = 0; i < 5; i++) begin
      mem_op_i = ops[i]; mem_addr_i = addrs[i]; reg_we_i = 1'b1; reg_waddr_i = 5'd1;
      tick();
      dbus_ack_i = 1'b1; dbus_rdata_i = rds[i];
      tick();
      dbus_ack_i = 1'b0;
      #1;
      tests_run++;
      if (reg_wdata_o !== exps[i]) begin
        $display("FAIL load_format_%0d: got %h want %h", i, reg_wdata_o, exps[i]);
        tests_failed++;
      end
      tick();
      drive_nop();
    end
  endtask

  task automatic test_timeout();
    mem_op_i = OP_LW; mem_addr_i = 32'h4000; reg_we_i = 1'b1; reg_waddr_i = 5'd7;
    tick();
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if ({dbus_req_o, stall_req_o} !== 2'b11) begin
        $display("FAIL timeout_hold_%0d: req=%b stall=%b want 1 1", i, dbus_req_o,
                 stall_req_o); tests_failed++;
      end
      tick();
    end
    tests_run++;
    if ({dbus_req_o, stall_req_o, reg_we_o} !== 3'b000) begin
      $display("FAIL timeout_done: req=%b stall=%b we=%b want 0 0 0", dbus_req_o,
               stall_req_o, reg_we_o); tests_failed++;
    end
    tests_run++;
    if (exception_o !== 32'h0000_0020) begin
      $display("FAIL timeout_exc: got %h want 00000020", exception_o); tests_failed++;
    end
    tick();
    drive_nop();
  endtask

  task automatic test_store_err();
    mem_op_i = OP_SB; mem_we_i = 1'b1; mem_addr_i = 32'h2001; mem_data_i = 32'hFFFF_FF55;
    exception_i = 32'h1;
    tick();
    tests_run++;
    if ({dbus_be_o, dbus_wdata_o} !== {4'b0010, 32'h5555_5555}) begin
      $display("FAIL sb_lanes: be=%b wdata=%h want 0010 55555555", dbus_be_o, dbus_wdata_o);
      tests_failed++;
    end
    dbus_ack_i = 1'b1; dbus_err_i = 1'b1;
    tick();
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
    #1;
    tests_run++;
    if (exception_o !== 32'h0000_0081) begin
      $display("FAIL store_err_exc: got %h want 00000081", exception_o); tests_failed++;
    end
    tick();
    drive_nop();
  endtask

  task automatic test_flush_busy();
    mem_op_i = OP_LW; mem_addr_i = 32'h5000; reg_we_i = 1'b1; reg_waddr_i = 5'd2;
    tick();
    flush_int_i = 1'b1;
    #1;
    tests_run++;
    if (stall_req_o !== 1'b1) begin
      $display("FAIL flush_busy_stall: got %b want 1", stall_req_o); tests_failed++;
    end
    tick();
    flush_int_i = 1'b0; mem_op_i = OP_NOP; mem_addr_i = 32'h0;
    #1;
    tests_run++;
    if ({dbus_req_o, stall_req_o, reg_we_o} !== 3'b100) begin
      $display("FAIL drain_state: req=%b stall=%b we=%b want 1 0 0", dbus_req_o,
               stall_req_o, reg_we_o); tests_failed++;
    end
    tick();
    tick();
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hBAD0_BAD0;
    #1;
    tests_run++;
    if (dbus_req_o !== 1'b1) begin
      $display("FAIL drain_req_held: got %b want 1", dbus_req_o); tests_failed++;
    end
    tick();
    dbus_ack_i = 1'b0;
    #1;
    tests_run++;
    if ({dbus_req_o, stall_req_o, reg_we_o, exception_o} !== {3'b001, 32'h0}) begin
      $display("FAIL drain_exit: req=%b stall=%b we=%b exc=%h want 0 0 1 0", dbus_req_o,
               stall_req_o, reg_we_o, exception_o); tests_failed++;
    end
    tick();
    drive_nop();
  endtask

  task automatic test_misalign();
    mem_op_i = OP_SW; mem_we_i = 1'b1; mem_addr_i = 32'h3001; mem_data_i = 32'hCAFE_BABE;
    reg_we_i = 1'b1;
`ifdef MEM_MISALIGN_EXC_EN
    #1;
    tests_run++;
    if ({stall_req_o, reg_we_o, exception_o} !== {2'b00, 32'h0000_0040}) begin
      $display("FAIL misalign_exc: stall=%b we=%b exc=%h want 0 0 00000040", stall_req_o,
               reg_we_o, exception_o); tests_failed++;
    end
    tick();
    tests_run++;
    if (dbus_req_o !== 1'b0) begin
      $display("FAIL misalign_no_req: got %b want 0", dbus_req_o); tests_failed++;
    end
    drive_nop();
`else
    #1;
    tests_run++;
    if (stall_req_o !== 1'b1) begin
      $display("FAIL wrap_stall: got %b want 1", stall_req_o); tests_failed++;
    end
    tick();
    tests_run++;
    if ({dbus_req_o, dbus_be_o, dbus_addr_o, dbus_wdata_o} !==
        {1'b1, 4'b1111, 32'h3000, 32'hCAFE_BABE}) begin
      $display("FAIL wrap_bus: req=%b be=%b addr=%h wdata=%h want 1 1111 3000 cafebabe",
               dbus_req_o, dbus_be_o, dbus_addr_o, dbus_wdata_o); tests_failed++;
    end
    dbus_ack_i = 1'b1;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    tests_run++;
    if (exception_o !== 32'h0) begin
      $display("FAIL wrap_exc: got %h want 0", exception_o); tests_failed++;
    end
    tick();
    drive_nop();
`endif
  endtask

  task automatic test_back_to_back();
    mem_op_i = OP_LW; mem_addr_i = 32'h6000; reg_we_i = 1'b1; reg_waddr_i = 5'd3;
    tick();
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    tests_run++;
    if ({stall_req_o, reg_we_o, reg_waddr_o, reg_wdata_o} !==
        {1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF}) begin
      $display("FAIL b2b_first: stall=%b we=%b rd=%0d data=%h want 0 1 3 deadbeef",
               stall_req_o, reg_we_o, reg_waddr_o, reg_wdata_o); tests_failed++;
    end
    tick();
    mem_addr_i = 32'h6004; reg_waddr_i = 5'd4;
    #1;
    tests_run++;
    if ({stall_req_o, dbus_req_o} !== 2'b10) begin
      $display("FAIL b2b_second_issue: stall=%b req=%b want 1 0", stall_req_o, dbus_req_o);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (dbus_addr_o !== 32'h6004) begin
      $display("FAIL b2b_second_addr: got %h want 00006004", dbus_addr_o); tests_failed++;
    end
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hCAFE_F00D;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    tests_run++;
    if ({stall_req_o, reg_we_o, reg_waddr_o, reg_wdata_o} !==
        {1'b0, 1'b1, 5'd4, 32'hCAFE_F00D}) begin
      $display("FAIL b2b_second: stall=%b we=%b rd=%0d data=%h want 0 1 4 cafef00d",
               stall_req_o, reg_we_o, reg_waddr_o, reg_wdata_o); tests_failed++;
    end
    tick();
    drive_nop();
  endtask

  task automatic test_reset_mid_busy();
    mem_op_i = OP_LW; mem_addr_i = 32'h7000;
    tick();
    #2 rst_i = 1'b0;
    drive_nop();
    #1;
    tests_run++;
    if ({dbus_req_o, dbus_addr_o} !== {1'b0, 32'h0}) begin
      $display("FAIL reset_mid_busy: req=%b addr=%h want 0 0", dbus_req_o, dbus_addr_o);
      tests_failed++;
    end
    @(negedge clk_i) rst_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_load_formats();
    test_timeout();
    test_store_err();
    test_flush_busy();
    test_misalign();
    test_back_to_back();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
